fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Initiator side of the instruction-memory interface. Owns the program counter and drives the chip-enable and address that the combinational instruction ROM answers in the same cycle. Registers the returned word, with its PC, into the IF/ID pipeline register. Handles stall, branch redirect (MIPS delay-slot semantics), pipeline flush and misaligned-fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetched address.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
stall  input  1  hold request from later pipeline stages.
flush  input  1  exception/eret flush from control.
flush_pc  input  inst_addr_t (32)  restart address used with flush.
branch_flag  input  1  taken branch/jump resolved in ID.
branch_target  input  inst_addr_t (32)  branch destination.
inst  input  inst_t (32)  word returned by ROM for current pc/ce.
ce  output  chip_status_t  ROM chip enable.
pc  output  inst_addr_t (32)  fetch address to ROM.
id_pc  output  inst_addr_t (32)  PC of instruction held in IF/ID.
id_inst  output  inst_t (32)  instruction held in IF/ID.
id_valid  output  1  IF/ID holds a real instruction.
id_adel  output  1  IF/ID entry is a misaligned fetch (AdEL).

Behaviour:
- Reset (rst_n=0 at an edge): ce=CHIP_DISABLE, pc=RESET_PC, id_pc=0, id_inst=0, id_valid=0, id_adel=0, pending=0, pending_target=0, state=S_IDLE.
- Reset mid-operation: same values at the next edge; in-flight pending redirect discarded.
- FSM, two states:
  - S_IDLE: ce=CHIP_DISABLE, pc held. First edge with rst_n=1 goes to S_FETCH and sets ce=CHIP_ENABLE. No IF/ID capture on that edge.
  - S_FETCH: ce=CHIP_ENABLE permanently until reset.
- ce is a registered output. The first enabled fetch is at RESET_PC, one cycle after reset release.
- Capture (S_FETCH, flush=0, stall=0):
  - id_pc<=pc, id_inst<=inst, id_valid<=1, id_adel<=0.
  - pc<=next_pc.
- next_pc priority:
  1. branch_flag: branch_target.
  2. pending: pending_target; clear pending.
  3. otherwise: pc+PC_STEP, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- Delay slot: the word fetched in the cycle branch_flag is seen is captured normally, never squashed.
- Stall (flush=0, stall=1): pc and all id_* hold; ce stays enabled.
  - If branch_flag=1: pending<=1, pending_target<=branch_target.
  - A later branch during the same stall overwrites pending_target.
- Flush (overrides stall and branch):
  - pc<=flush_pc; id_valid<=0, id_inst<=0, id_adel<=0; pending<=0.
  - id_pc<=0.
- Flush while in S_IDLE: pc<=flush_pc, state unchanged.
- Misaligned fetch: if pc[1:0]!=0 at a capture edge:
  - id_inst<=0 (nop), id_adel<=1, id_valid<=1, id_pc<=pc.
  - next_pc computed normally. Control is expected to flush.
- No combinational path from inputs to ce/pc; pc, ce and id_* are all flops.

Decomposition:
- Package project_types already holds chip_status_t (CHIP_ENABLE/CHIP_DISABLE), inst_addr_t and inst_t.
- Add to project_types: fetch_state_t (S_IDLE, S_FETCH), localparam RESET_PC_DEFAULT, and NOP_INST = 32'h0.
- Sub-module pc_next_sel: combinational next-pc priority mux (flush/branch/pending/sequential). Everything else stays flat.

Test Plan:
- Reset, then release rst_n -> cycle 0 after release: ce=DISABLE, pc=0. Cycle 1: ce=ENABLE, pc=0. Cycle 2: id_pc=0, id_valid=1, pc=4.
- Free run, ROM loaded with inst_mem[n]=n -> id_pc/id_inst sequence 0/0, 4/1, 8/2 on consecutive cycles, no gaps.
- At pc=0x10, branch_flag=1, target=0x40 -> delay slot 0x10 captured, next id_pc=0x40.
- stall=1 for 3 cycles with branch_flag pulse (target 0x80) in the 2nd -> pc/id_* frozen. After release: capture of held pc, then pc=0x80, then id_pc=0x80.
- flush=1, flush_pc=0x180, together with stall=1 and pending redirect -> next cycle pc=0x180, id_valid=0, pending cleared. Following capture id_pc=0x180.
- branch_target=0x42 -> id_adel=1, id_inst=0, id_pc=0x42. Next pc=0x46 if no flush.
- Force pc=32'hFFFF_FFFC via flush -> next pc=0.

Source files
------------

// File: rtl/project_types.sv
// Shared types for the fetch path: chip-enable encoding, address/instruction
// words, fetch FSM states and reset/nop constants.
package project_types;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_status_t;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_t;

  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam inst_t      NOP_INST         = 32'h0000_0000;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input inst_addr_t addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next program-counter selection. Priority: flush restart, resolved branch,
// redirect remembered during a stall, then sequential increment (wraps at 2^32).
module pc_next_sel
  import project_types::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic       flush,
  input  inst_addr_t flush_pc,
  input  logic       branch_flag,
  input  inst_addr_t branch_target,
  input  logic       pending,
  input  inst_addr_t pending_target,
  input  inst_addr_t pc,
  output inst_addr_t next_pc
);

  localparam inst_addr_t STEP = inst_addr_t'(PC_STEP);

  // Priority mux for the next fetch address.
  always_comb begin
    next_pc = pc + STEP;
    if (flush) begin
      next_pc = flush_pc;
    end else if (branch_flag) begin
      next_pc = branch_target;
    end else if (pending) begin
      next_pc = pending_target;
    end else begin
      next_pc = pc + STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM chip enable/address,
// and registers the returned word with its PC into the IF/ID register.
// Handles stall, delay-slot branch redirect, flush and misaligned fetch.
module fetch_unit
  import project_types::*;
#(
  parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter int         PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  inst_addr_t   flush_pc,
  input  logic         branch_flag,
  input  inst_addr_t   branch_target,
  input  inst_t        inst,
  output chip_status_t ce,
  output inst_addr_t   pc,
  output inst_addr_t   id_pc,
  output inst_t        id_inst,
  output logic         id_valid,
  output logic         id_adel
);

  fetch_state_t state;
  fetch_state_t next_state;
  logic         pending;
  inst_addr_t   pending_target;
  inst_addr_t   next_pc;

  pc_next_sel #(
    .PC_STEP(PC_STEP)
  ) u_pc_next_sel (
    .flush          (flush),
    .flush_pc       (flush_pc),
    .branch_flag    (branch_flag),
    .branch_target  (branch_target),
    .pending        (pending),
    .pending_target (pending_target),
    .pc             (pc),
    .next_pc        (next_pc)
  );

  // Next-state logic: leave idle on the first non-flushed edge out of reset.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (flush) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: next_state = S_FETCH;
      default: next_state = S_IDLE;
    endcase
  end

  // State register and registered chip enable derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ce    <= CHIP_DISABLE;
    end else begin
      state <= next_state;
      ce    <= (next_state == S_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;
    end
  end

  // PC, pending redirect and IF/ID register updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      id_pc          <= 32'h0000_0000;
      id_inst        <= NOP_INST;
      id_valid       <= 1'b0;
      id_adel        <= 1'b0;
      pending        <= 1'b0;
      pending_target <= 32'h0000_0000;
    end else if (state == S_IDLE) begin
      // No capture before the first enabled fetch; only a flush moves the PC.
      if (flush) begin
        pc <= flush_pc;
      end
    end else if (flush) begin
      pc       <= next_pc;
      id_pc    <= 32'h0000_0000;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
      pending  <= 1'b0;
    end else if (stall) begin
      // Hold everything; remember the most recent branch seen while stalled.
      if (branch_flag) begin
        pending        <= 1'b1;
        pending_target <= branch_target;
      end
    end else begin
      // Normal capture; the delay-slot word is kept, never squashed.
      id_pc    <= pc;
      id_valid <= 1'b1;
      if (is_misaligned(pc)) begin
        id_inst <= NOP_INST;
        id_adel <= 1'b1;
      end else begin
        id_inst <= inst;
        id_adel <= 1'b0;
      end
      pc      <= next_pc;
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/branch/flush/reset traffic, checked against a cycle-level model.
module tb_fetch_unit;
  import project_types::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         flush;
  inst_addr_t   flush_pc;
  logic         branch_flag;
  inst_addr_t   branch_target;
  inst_t        inst;
  chip_status_t ce;
  inst_addr_t   pc;
  inst_addr_t   id_pc;
  inst_t        id_inst;
  logic         id_valid;
  logic         id_adel;

  int compares = 0;
  int fails    = 0;

  // Reference model state
  logic        m_started;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_ptarget;
  logic        m_id_valid, m_id_adel, m_pending;

  always #5 clk = ~clk;

  // ROM: word n holds value n (combinational)
  assign inst = pc >> 2;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .flush_pc(flush_pc), .branch_flag(branch_flag),
    .branch_target(branch_target), .inst(inst), .ce(ce), .pc(pc),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_adel(id_adel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ce",       {31'b0, ce},       {31'b0, m_started});
    check("pc",       pc,                m_pc);
    check("id_pc",    id_pc,             m_id_pc);
    check("id_inst",  id_inst,           m_id_inst);
    check("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    check("id_adel",  {31'b0, id_adel},  {31'b0, m_id_adel});
  endtask

  // Advance model one clock using current inputs, clock the DUT, then compare.
  task automatic step();
    if (!rst_n) begin
      m_started = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0;
      m_id_valid = 1'b0; m_id_adel = 1'b0; m_pending = 1'b0; m_ptarget = 32'h0;
    end else if (!m_started) begin
      if (flush) m_pc = flush_pc;
      else m_started = 1'b1;
    end else if (flush) begin
      m_pc = flush_pc; m_id_pc = 32'h0; m_id_inst = 32'h0;
      m_id_valid = 1'b0; m_id_adel = 1'b0; m_pending = 1'b0;
    end else if (stall) begin
      if (branch_flag) begin
        m_pending = 1'b1; m_ptarget = branch_target;
      end
    end else begin
      m_id_pc    = m_pc;
      m_id_valid = 1'b1;
      m_id_adel  = (m_pc % 4 != 0);
      m_id_inst  = m_id_adel ? 32'h0 : m_pc / 4;
      if (branch_flag)    m_pc = branch_target;
      else if (m_pending) m_pc = m_ptarget;
      else                m_pc = m_pc + 32'd4;
      m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] fpc,
                       input logic b, input logic [31:0] bt);
    stall = s; flush = f; flush_pc = fpc; branch_flag = b; branch_target = bt;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); step();

    // Reset release: first edge still disabled before it
    rst_n = 1'b1;
    check("rel0_ce", {31'b0, ce}, 32'h0);
    check("rel0_pc", pc, 32'h0);
    step();
    check("rel1_ce", {31'b0, ce}, 32'h1);
    step();
    check("rel2_id_pc", id_pc, 32'h0);
    check("rel2_pc", pc, 32'h4);
    step(); step();
    check("seq_id_inst", id_inst, 32'h2);
    step();
    check("pc_at_10", pc, 32'h10);

    // Branch with delay slot
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    step();
    check("delay_slot_pc", id_pc, 32'h10);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("branch_id_pc", id_pc, 32'h40);

    // Stall three cycles with a branch pulse in the second
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h80); step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); step();
    check("stall_hold_pc", pc, 32'h44);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    check("stall_rel_id", id_pc, 32'h44);
    check("stall_rel_pc", pc, 32'h80);
    step();
    check("pend_id_pc", id_pc, 32'h80);

    // Flush overrides stall and pending redirect
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h300); step();
    drive(1'b1, 1'b1, 32'h180, 1'b0, 32'h0); step();
    check("flush_pc", pc, 32'h180);
    check("flush_valid", {31'b0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    check("flush_cap", id_pc, 32'h180);
    check("flush_no_pend", pc, 32'h184);

    // Misaligned branch target
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h42); step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    check("adel", {31'b0, id_adel}, 32'h1);
    check("adel_inst", id_inst, 32'h0);
    check("adel_pc", id_pc, 32'h42);
    check("adel_next", pc, 32'h46);

    // PC wrap
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_id", id_pc, 32'hFFFF_FFFC);

    // Mid-operation reset discards pending redirect
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h500); step();
    rst_n = 1'b0; drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    rst_n = 1'b1; step(); step(); step();
    check("rst_no_pend", pc, 32'h8);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            $urandom & 32'h0000_0FFC, $urandom_range(0, 6) == 0, t);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
